// File: rtl/axis_frame_monitor.sv
// Passive multi-channel AXI4-Stream video geometry monitor (ppl/lpf/fps, sticky errors).
// Define AXIS_FRAME_MON_FPS_EN to build the window counter, frame counters, fps_o and upd_o.
module axis_frame_monitor #(
  parameter int CH_CNT      = 2,
  parameter int REFCLK_FREQ = 100_000_000,
  parameter int PIX_WID     = 12,
  parameter int LINE_WID    = 12,
  parameter int FRM_WID     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_CNT-1:0]            axis_tvalid,
  input  logic [CH_CNT-1:0]            axis_tready,
  input  logic [CH_CNT-1:0]            axis_tuser,
  input  logic [CH_CNT-1:0]            axis_tlast,
  input  logic [PIX_WID-1:0]           exp_ppl,
  input  logic [LINE_WID-1:0]          exp_lpf,
  input  logic                         clr_err,
  output logic [CH_CNT*PIX_WID-1:0]    ppl_o,
  output logic [CH_CNT*LINE_WID-1:0]   lpf_o,
  output logic [CH_CNT*FRM_WID-1:0]    fps_o,
  output logic [CH_CNT*4-1:0]          err_o,
  output logic                         upd_o
);

  typedef enum logic {SYNC, RUN} st_t;

`ifdef AXIS_FRAME_MON_FPS_EN
  localparam int WC_W = (REFCLK_FREQ > 1) ? $clog2(REFCLK_FREQ) : 1;

  logic [WC_W-1:0] wc;
  logic            win_tc;

  assign win_tc = (wc == WC_W'(REFCLK_FREQ - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wc    <= '0;
      upd_o <= 1'b0;
    end else begin
      wc    <= win_tc ? '0 : wc + 1'b1;
      upd_o <= win_tc;
    end
  end
`else
  assign fps_o = '0;
  assign upd_o = 1'b0;
`endif

  for (genvar c = 0; c < CH_CNT; c++) begin : g_ch
    st_t                st, st_nx;
    logic               beat, sof, eol, run;
    logic [PIX_WID-1:0] pc, ppl_q;
    logic [PIX_WID:0]   len;
    logic [LINE_WID-1:0] lc, lpf_q;
    logic [3:0]         err_q, err_ev;

    assign beat = axis_tvalid[c] & axis_tready[c];
    assign sof  = beat & axis_tuser[c];
    assign eol  = beat & axis_tlast[c];
    assign len  = {1'b0, pc} + 1'b1;

    always_ff @(posedge clk) begin
      if (rst) st <= SYNC;
      else     st <= st_nx;
    end

    always_comb begin
      st_nx = st;
      unique case (st)
        SYNC:    if (sof) st_nx = RUN;
        RUN:     st_nx = RUN;
        default: st_nx = SYNC;
      endcase
    end

    always_comb begin
      run    = (st == RUN);
      err_ev = '0;
      if (run && eol) begin
        err_ev[0] = (len < {1'b0, exp_ppl});
        err_ev[1] = (len > {1'b0, exp_ppl});
      end
      if (run && sof) begin
        err_ev[2] = (lc != exp_lpf);
        err_ev[3] = (pc != '0);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pc    <= '0;
        lc    <= '0;
        ppl_q <= '0;
        lpf_q <= '0;
        err_q <= '0;
      end else begin
        // a tuser beat is always pixel 0 of a new line
        if (eol)                        pc <= '0;
        else if (sof)                   pc <= PIX_WID'(1);
        else if (beat && (pc != '1))    pc <= pc + 1'b1;

        if (run && eol)
          ppl_q <= len[PIX_WID] ? '1 : len[PIX_WID-1:0];

        if (sof)                        lc <= LINE_WID'(eol);
        else if (eol && (lc != '1))     lc <= lc + 1'b1;

        if (run && sof) lpf_q <= lc;

        err_q <= clr_err ? err_ev : (err_q | err_ev);
      end
    end

    assign ppl_o[c*PIX_WID +: PIX_WID]   = ppl_q;
    assign lpf_o[c*LINE_WID +: LINE_WID] = lpf_q;
    assign err_o[c*4 +: 4]               = err_q;

`ifdef AXIS_FRAME_MON_FPS_EN
    logic [FRM_WID-1:0] fc, fps_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        fc    <= '0;
        fps_q <= '0;
      end else if (win_tc) begin
        fps_q <= fc;
        fc    <= FRM_WID'(sof);
      end else if (sof && (fc != '1)) begin
        fc <= fc + 1'b1;
      end
    end

    assign fps_o[c*FRM_WID +: FRM_WID] = fps_q;
`endif
  end

endmodule
